// File: rtl/exception_ctrl.sv
// ---------------------------------------------------------------------------
// exception_ctrl
//   Exception / interrupt controller for the single-cycle CPU. Latches rising
//   edges on three external exception sources, prioritises them against
//   SYSCALL, redirects the PC to a handler vector and returns to EPC on ERET.
//   Holds CP0-style STATUS / CAUSE / EPC registers behind a simple port.
//
//   Optional build macro: EXC_SYNC_EN
//     defined   : 2-flop synchroniser on each expSrc before edge detection
//                 (external events arrive two cycles later; SYSCALL unchanged)
//     undefined : expSrc sampled directly; inputs must already be synchronous
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   expSrc0..2      external exception sources (0 = highest priority)
//   is_syscall      current instruction is SYSCALL
//   is_eret         current instruction is ERET
//   pc_next         CPU's normal next PC, captured into EPC on a take
//   cp0_we/sel/wdata CP0 write port (0=STATUS 1=CAUSE 2=EPC 3=reserved)
//   cp0_rdata       CP0 read data, combinational on cp0_sel
//   exc_take        exception taken this cycle, PC <= redirect_pc
//   eret_take       ERET accepted this cycle, PC <= redirect_pc
//   redirect_pc     handler vector or EPC, 0 when no take is active
//   epc             EPC register
//   in_service      handler active (STATUS.EXL)
//   double_fault    sticky: SYSCALL seen while in service
// ---------------------------------------------------------------------------
module exception_ctrl #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0800,
  parameter logic [4:0]  CODE_SYS = 5'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        expSrc0,
  input  logic        expSrc1,
  input  logic        expSrc2,
  input  logic        is_syscall,
  input  logic        is_eret,
  input  logic [31:0] pc_next,
  input  logic        cp0_we,
  input  logic [1:0]  cp0_sel,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        exc_take,
  output logic        eret_take,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc,
  output logic        in_service,
  output logic        double_fault
);

  typedef enum logic {S_IDLE = 1'b0, S_SERVICE = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [2:0]  w_src;
  logic [2:0]  r_prev;
  logic [2:0]  r_pending;
  logic [3:0]  r_status;      // [0] IE, [3:1] mask for src2..src0
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic        r_dfault;

  logic [2:0]  w_rise;
  logic [2:0]  w_req;
  logic [2:0]  w_win_oh;
  logic [2:0]  w_clr;
  logic [4:0]  w_exc_code;
  logic        w_exc_take;
  logic        w_eret_take;
  logic        w_sys_take;
  logic        w_ext_take;
  logic        w_exl;

  // Lowest-index requesting source wins; result is one-hot (or zero).
  function automatic logic [2:0] pick_lowest(input logic [2:0] req);
    logic [2:0] oh;
    oh = 3'b000;
    if (req[0])      oh = 3'b001;
    else if (req[1]) oh = 3'b010;
    else if (req[2]) oh = 3'b100;
    return oh;
  endfunction

  // External sources use ExcCode 1/2/3 for src0/1/2.
  function automatic logic [4:0] ext_code(input logic [2:0] oh);
    logic [4:0] c;
    c = 5'd0;
    if (oh[0])      c = 5'd1;
    else if (oh[1]) c = 5'd2;
    else if (oh[2]) c = 5'd3;
    return c;
  endfunction

`ifdef EXC_SYNC_EN
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= {expSrc2, expSrc1, expSrc0};
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = {expSrc2, expSrc1, expSrc0};
`endif

  assign w_exl    = (r_state == S_SERVICE);
  assign w_rise   = w_src & ~r_prev;
  assign w_req    = r_pending & r_status[3:1];
  assign w_win_oh = pick_lowest(w_req);

  // Take decision: SYSCALL bypasses IE and mask; nothing is taken in SERVICE.
  always_comb begin
    w_state_nxt = r_state;
    w_exc_take  = 1'b0;
    w_eret_take = 1'b0;
    w_sys_take  = 1'b0;
    w_ext_take  = 1'b0;
    if (r_state == S_IDLE) begin
      if (is_syscall) begin
        w_sys_take = 1'b1;
        w_exc_take = 1'b1;
      end else if (r_status[0] && (|w_req)) begin
        w_ext_take = 1'b1;
        w_exc_take = 1'b1;
      end
      if (w_exc_take) w_state_nxt = S_SERVICE;
    end else begin
      if (is_eret) begin
        w_eret_take = 1'b1;
        w_state_nxt = S_IDLE;
      end
    end
  end

  assign w_exc_code = w_sys_take ? CODE_SYS : ext_code(w_win_oh);
  // A SYSCALL take leaves external pending bits untouched.
  assign w_clr      = w_ext_take ? w_win_oh : 3'b000;

  always_comb begin
    redirect_pc = 32'h0;
    if (w_exc_take)       redirect_pc = VEC_BASE + {23'h0, w_exc_code, 4'h0};
    else if (w_eret_take) redirect_pc = r_epc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Edge capture: a new rising edge on the winner at its take edge re-sets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev    <= 3'b000;
      r_pending <= 3'b000;
    end else begin
      r_prev    <= w_src;
      r_pending <= (r_pending & ~w_clr) | w_rise;
    end
  end

  // CP0 registers: hardware EPC capture beats a software EPC write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status  <= 4'hF;
      r_exccode <= 5'd0;
      r_epc     <= 32'h0;
      r_dfault  <= 1'b0;
    end else begin
      if (cp0_we && (cp0_sel == 2'd0)) r_status <= cp0_wdata[3:0];
      if (w_exc_take) begin
        r_exccode <= w_exc_code;
        r_epc     <= pc_next;
      end else if (cp0_we && (cp0_sel == 2'd2)) begin
        r_epc     <= cp0_wdata;
      end
      if (w_exl && is_syscall) r_dfault <= 1'b1;
    end
  end

  always_comb begin
    cp0_rdata = 32'h0;
    case (cp0_sel)
      2'd0:    cp0_rdata = {27'h0, w_exl, r_status};
      2'd1:    cp0_rdata = {21'h0, r_pending, 1'b0, r_exccode, 2'b00};
      2'd2:    cp0_rdata = r_epc;
      default: cp0_rdata = 32'h0;
    endcase
  end

  assign exc_take     = w_exc_take;
  assign eret_take    = w_eret_take;
  assign epc          = r_epc;
  assign in_service   = w_exl;
  assign double_fault = r_dfault;

endmodule

// File: tb/tb_exception_ctrl.sv
module tb_exception_ctrl;

`ifdef EXC_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk;
  logic        rst;
  logic        expSrc0, expSrc1, expSrc2;
  logic        is_syscall, is_eret;
  logic [31:0] pc_next;
  logic        cp0_we;
  logic [1:0]  cp0_sel;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        exc_take, eret_take;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic        in_service;
  logic        double_fault;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  exception_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .expSrc0      (expSrc0),
    .expSrc1      (expSrc1),
    .expSrc2      (expSrc2),
    .is_syscall   (is_syscall),
    .is_eret      (is_eret),
    .pc_next      (pc_next),
    .cp0_we       (cp0_we),
    .cp0_sel      (cp0_sel),
    .cp0_wdata    (cp0_wdata),
    .cp0_rdata    (cp0_rdata),
    .exc_take     (exc_take),
    .eret_take    (eret_take),
    .redirect_pc  (redirect_pc),
    .epc          (epc),
    .in_service   (in_service),
    .double_fault (double_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check_v(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h, no expected value queued", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic read_cp0(input logic [1:0] sel, output logic [31:0] d);
    cp0_sel = sel;
    #1;
    d = cp0_rdata;
  endtask

  // Bounded wait for exc_take; returns the number of ticks spent waiting.
  task automatic wait_take(input int max, output int cyc);
    cyc = 0;
    settle();
    while (!exc_take && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  logic [31:0] rd;
  int          cyc;

  initial begin
    rst = 1'b1;
    expSrc0 = 0; expSrc1 = 0; expSrc2 = 0;
    is_syscall = 0; is_eret = 0;
    pc_next = 32'h0;
    cp0_we = 0; cp0_sel = 2'd0; cp0_wdata = 32'h0;
    tick(); tick();

    // Reset state
    expect_v("rst_exc_take", 32'h0);   settle(); check_v({31'h0, exc_take});
    expect_v("rst_redirect", 32'h0);   check_v(redirect_pc);
    expect_v("rst_in_service", 32'h0); check_v({31'h0, in_service});
    expect_v("rst_dfault", 32'h0);     check_v({31'h0, double_fault});
    expect_v("rst_status", 32'hF);     read_cp0(2'd0, rd); check_v(rd);
    expect_v("rst_epc", 32'h0);        check_v(epc);
    rst = 1'b0;
    tick();

    // 1: expSrc1 pulse
    pc_next = 32'h1004;
    expSrc1 = 1'b1;
    tick();
    expSrc1 = 1'b0;
    expect_v("s1_latency", SYNC_LAT);
    wait_take(6, cyc);
    check_v(cyc);
    expect_v("s1_exc_take", 32'h1);    check_v({31'h0, exc_take});
    expect_v("s1_redirect", 32'h820);  check_v(redirect_pc);
    tick();
    expect_v("s1_epc", 32'h1004);      settle(); check_v(epc);
    expect_v("s1_cause", 32'h8);       read_cp0(2'd1, rd); check_v(rd);
    expect_v("s1_in_service", 32'h1);  check_v({31'h0, in_service});
    expect_v("s1_status_exl", 32'h1F); read_cp0(2'd0, rd); check_v(rd);
    is_eret = 1'b1;
    expect_v("s1_eret_take", 32'h1);   settle(); check_v({31'h0, eret_take});
    expect_v("s1_eret_pc", 32'h1004);  check_v(redirect_pc);
    tick();
    is_eret = 1'b0;
    expect_v("s1_exl_clr", 32'h0);     settle(); check_v({31'h0, in_service});

    // 2: src0 and src2 together, src0 first, src2 after ERET
    pc_next = 32'h3000;
    expSrc0 = 1'b1; expSrc2 = 1'b1;
    tick();
    expSrc0 = 1'b0; expSrc2 = 1'b0;
    wait_take(6, cyc);
    expect_v("s2_take0", 32'h1);       check_v({31'h0, exc_take});
    expect_v("s2_redirect0", 32'h810); check_v(redirect_pc);
    tick();
    expect_v("s2_cause", 32'h404);     read_cp0(2'd1, rd); check_v(rd);
    expect_v("s2_epc", 32'h3000);      check_v(epc);
    is_eret = 1'b1;
    settle();
    expect_v("s2_eret_take", 32'h1);   check_v({31'h0, eret_take});
    expect_v("s2_no_take_eret", 32'h0);check_v({31'h0, exc_take});
    expect_v("s2_eret_pc", 32'h3000);  check_v(redirect_pc);
    tick();
    is_eret = 1'b0;
    pc_next = 32'h3010;
    settle();
    expect_v("s2_take2", 32'h1);       check_v({31'h0, exc_take});
    expect_v("s2_redirect2", 32'h830); check_v(redirect_pc);
    tick();
    expect_v("s2_cause2", 32'hC);      read_cp0(2'd1, rd); check_v(rd);
    expect_v("s2_epc2", 32'h3010);     check_v(epc);
    is_eret = 1'b1;
    tick();
    is_eret = 1'b0;

    // 3: syscall and double fault
    pc_next = 32'h2008;
    is_syscall = 1'b1;
    settle();
    expect_v("s3_take", 32'h1);        check_v({31'h0, exc_take});
    expect_v("s3_redirect", 32'h880);  check_v(redirect_pc);
    tick();
    is_syscall = 1'b0;
    expect_v("s3_epc", 32'h2008);      settle(); check_v(epc);
    expect_v("s3_cause", 32'h20);      read_cp0(2'd1, rd); check_v(rd);
    expect_v("s3_df0", 32'h0);         check_v({31'h0, double_fault});
    is_syscall = 1'b1;
    settle();
    expect_v("s3_no_take", 32'h0);     check_v({31'h0, exc_take});
    tick();
    is_syscall = 1'b0;
    expect_v("s3_df1", 32'h1);         settle(); check_v({31'h0, double_fault});
    expect_v("s3_epc_kept", 32'h2008); check_v(epc);
    is_eret = 1'b1;
    tick();
    is_eret = 1'b0;

    // 4: masked source
    cp0_we = 1'b1; cp0_sel = 2'd0; cp0_wdata = 32'h7;
    tick();
    cp0_we = 1'b0;
    expSrc2 = 1'b1;
    tick();
    expSrc2 = 1'b0;
    for (int i = 0; i < SYNC_LAT + 2; i++) tick();
    expect_v("s4_masked", 32'h0);      settle(); check_v({31'h0, exc_take});
    expect_v("s4_cause", 32'h420);     read_cp0(2'd1, rd); check_v(rd);
    expect_v("s4_status", 32'h7);      read_cp0(2'd0, rd); check_v(rd);
    pc_next = 32'h4000;
    cp0_we = 1'b1; cp0_sel = 2'd0; cp0_wdata = 32'hF;
    tick();
    cp0_we = 1'b0;
    expect_v("s4_take", 32'h1);        settle(); check_v({31'h0, exc_take});
    expect_v("s4_redirect", 32'h830);  check_v(redirect_pc);
    tick();
    expect_v("s4_cause2", 32'hC);      read_cp0(2'd1, rd); check_v(rd);
    expect_v("s4_in_service", 32'h1);  check_v({31'h0, in_service});

    // 5: pending accumulates in service, reset mid-service, ERET in IDLE
    expSrc0 = 1'b1;
    tick();
    expSrc0 = 1'b0;
    for (int i = 0; i < SYNC_LAT; i++) tick();
    tick();
    expect_v("s5_pend_acc", 32'h10C);  read_cp0(2'd1, rd); check_v(rd);
    rst = 1'b1;
    settle();
    expect_v("s5_rst_insvc", 32'h0);   check_v({31'h0, in_service});
    expect_v("s5_rst_status", 32'hF);  read_cp0(2'd0, rd); check_v(rd);
    expect_v("s5_rst_epc", 32'h0);     check_v(epc);
    expect_v("s5_rst_cause", 32'h0);   read_cp0(2'd1, rd); check_v(rd);
    expect_v("s5_rst_df", 32'h0);      check_v({31'h0, double_fault});
    tick();
    rst = 1'b0;
    tick();
    is_eret = 1'b1;
    settle();
    expect_v("s5_eret_idle", 32'h0);   check_v({31'h0, eret_take});
    expect_v("s5_redirect0", 32'h0);   check_v(redirect_pc);
    tick();
    is_eret = 1'b0;
    expect_v("s5_no_take", 32'h0);     settle(); check_v({31'h0, exc_take});

    // Held-high level takes once and does not re-trigger after ERET
    expSrc1 = 1'b1;
    tick();
    wait_take(6, cyc);
    expect_v("lvl_take", 32'h1);       check_v({31'h0, exc_take});
    tick();
    is_eret = 1'b1;
    tick();
    is_eret = 1'b0;
    for (int i = 0; i < SYNC_LAT + 2; i++) tick();
    expect_v("lvl_no_retrig", 32'h0);  settle(); check_v({31'h0, exc_take});
    expSrc1 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
